// File: rtl/fifo_async_write_arbiter.sv
// rtl/fifo_async_write_arbiter.sv - round-robin, packet-locked write-port arbiter for the async FIFO
module fifo_async_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk_in,
    input  logic                   nrst_in,
    input  logic [N_REQ-1:0]       req_valid_in,
    input  logic [N_REQ-1:0]       req_last_in,
    input  logic [N_REQ*WIDTH-1:0] req_data_in,
    output logic [N_REQ-1:0]       req_ready_out,
    output logic [N_REQ-1:0]       grant_out,
    output logic                   fifo_write_out,
    output logic [WIDTH-1:0]       fifo_wdata_out,
    input  logic                   fifo_full_in,
    output logic                   busy_out
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               owner_valid;
    logic               owner_last;
    logic [WIDTH-1:0]   owner_data;
    logic               xfer;
    logic               release_now;

    // Scan from farthest to nearest so the index closest after last_idx wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % N_REQ);
            if (req_valid_in[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_data = req_data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_valid    = |(req_valid_in & grant);
    assign owner_last     = |(req_last_in & grant);
    assign busy_out       = (state == BURST);
    assign grant_out      = grant;
    assign req_ready_out  = (busy_out && !fifo_full_in) ? grant : '0;
    assign xfer           = busy_out && owner_valid && !fifo_full_in;
    assign fifo_write_out = xfer;
    assign fifo_wdata_out = busy_out ? owner_data : '0;
    assign release_now    = xfer && (owner_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            last_idx <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= N_REQ'(1) << pick_idx;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (release_now) begin
                        grant    <= '0;
                        beat_cnt <= '0;
                        last_idx <= owner;
                        state    <= IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_async_write_arbiter.sv
// tb/tb_fifo_async_write_arbiter.sv - directed self-checking bench for fifo_async_write_arbiter
module tb_fifo_async_write_arbiter;

    logic        clk_in = 1'b0;
    logic        nrst_in;
    logic [3:0]  req_valid_in;
    logic [3:0]  req_last_in;
    logic [31:0] req_data_in;
    logic [3:0]  req_ready_out;
    logic [3:0]  grant_out;
    logic        fifo_write_out;
    logic [7:0]  fifo_wdata_out;
    logic        fifo_full_in;
    logic        busy_out;

    fifo_async_write_arbiter #(
        .WIDTH(8), .N_REQ(4), .IDX_W(2), .MAX_BURST(4)
    ) dut (
        .clk_in(clk_in), .nrst_in(nrst_in),
        .req_valid_in(req_valid_in), .req_last_in(req_last_in), .req_data_in(req_data_in),
        .req_ready_out(req_ready_out), .grant_out(grant_out),
        .fifo_write_out(fifo_write_out), .fifo_wdata_out(fifo_wdata_out),
        .fifo_full_in(fifo_full_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] bd [4][16];
    logic       bl [4][16];
    int         head [4];
    int         cnt  [4];

    logic [7:0] wlog [64];
    int         wt   [64];
    int         wn = 0;
    logic [3:0] glog [32];
    int         gn = 0;
    logic [3:0] prev_grant = '0;
    int         tcount = 0;

    int         stall_at = 0, stall_left = 0, stall_kind = 0;
    int         stall_cycles = 0, stall_err = 0, inv_err = 0;
    logic [3:0] stall_grant = '0;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] exp_d [16];
    logic [3:0] exp_g [8];
    int         base, gb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
    endtask

    task automatic load(input int r, input logic [7:0] d0, input int n);
        for (int k = 0; k < n; k++) begin
            bd[r][cnt[r]] = d0 + 8'(k);
            bl[r][cnt[r]] = (k == n - 1);
            cnt[r]++;
        end
    endtask

    task automatic drive(input bit stall);
        for (int i = 0; i < 4; i++) begin
            if (head[i] < cnt[i]) begin
                req_valid_in[i]        = !(stall && stall_kind == 1 && i == 1);
                req_last_in[i]         = bl[i][head[i]];
                req_data_in[i*8 +: 8]  = bd[i][head[i]];
            end else begin
                req_valid_in[i]        = 1'b0;
                req_last_in[i]         = 1'b0;
                req_data_in[i*8 +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic tick();
        bit stall;
        @(posedge clk_in);
        #1;
        tcount++;
        stall = (stall_left > 0) && (wn == stall_at);
        if (stall) begin
            stall_left--;
            stall_cycles++;
        end
        fifo_full_in = stall && (stall_kind == 0);
        drive(stall);
        #1;
        if (!$onehot0(grant_out)) inv_err++;
        if (fifo_write_out && !$onehot(req_ready_out)) inv_err++;
        if (stall && (fifo_write_out || (stall_kind == 0 && req_ready_out != 0)
                      || grant_out != stall_grant)) stall_err++;
        if (fifo_write_out && wn < 64) begin
            wlog[wn] = fifo_wdata_out;
            wt[wn]   = tcount;
            wn++;
        end
        if (grant_out != 0 && prev_grant == 0 && gn < 32) begin
            glog[gn] = grant_out;
            gn++;
        end
        prev_grant = grant_out;
        for (int i = 0; i < 4; i++)
            if (req_valid_in[i] && req_ready_out[i]) head[i]++;
    endtask

    task automatic check_log(input string tag, input int b, input int n);
        check({tag, "_count"}, wn - b, n);
        for (int k = 0; k < n; k++) check({tag, "_data"}, wlog[b + k], exp_d[k]);
    endtask

    task automatic check_grants(input string tag, input int b, input int n);
        check({tag, "_ngrant"}, gn - b, n);
        for (int k = 0; k < n; k++) check({tag, "_grant"}, glog[b + k], exp_g[k]);
    endtask

    initial begin
        nrst_in      = 1'b0;
        fifo_full_in = 1'b0;
        req_valid_in = '0;
        req_last_in  = '0;
        req_data_in  = '0;
        clear_model();
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_grant", grant_out, 0);
        check("rst_write", fifo_write_out, 0);
        check("rst_ready", req_ready_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_wdata", fifo_wdata_out, 0);
        nrst_in = 1'b1;

        // single-beat packets from all four requesters
        clear_model();
        for (int i = 0; i < 4; i++) load(i, 8'hA0 + 8'(i), 1);
        base = wn; gb = gn;
        repeat (12) tick();
        for (int k = 0; k < 4; k++) exp_d[k] = 8'hA0 + 8'(k);
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
        check_log("t1", base, 4);
        check_grants("t1", gb, 4);
        check("t1_bubble", wt[base + 1] - wt[base], 2);

        // packet lock: req2 waits for req1's whole packet
        clear_model();
        load(1, 8'h10, 4);
        load(2, 8'h20, 1);
        base = wn; gb = gn;
        repeat (12) tick();
        for (int k = 0; k < 4; k++) exp_d[k] = 8'h10 + 8'(k);
        exp_d[4] = 8'h20;
        exp_g[0] = 4'b0010; exp_g[1] = 4'b0100;
        check_log("t2", base, 5);
        check_grants("t2", gb, 2);

        // full for 3 cycles after beat 2
        clear_model();
        load(3, 8'h30, 4);
        base = wn; gb = gn;
        stall_at = base + 2; stall_left = 3; stall_kind = 0; stall_grant = 4'b1000;
        stall_cycles = 0; stall_err = 0;
        repeat (14) tick();
        for (int k = 0; k < 4; k++) exp_d[k] = 8'h30 + 8'(k);
        check_log("t3", base, 4);
        check("t3_stall_cycles", stall_cycles, 3);
        check("t3_stall_err", stall_err, 0);
        check("t3_resume", wt[base + 2] - wt[base + 1], 4);

        // forced release at MAX_BURST=4
        clear_model();
        load(0, 8'h40, 10);
        load(3, 8'h50, 1);
        base = wn; gb = gn;
        repeat (22) tick();
        for (int k = 0; k < 4; k++) exp_d[k] = 8'h40 + 8'(k);
        exp_d[4] = 8'h50;
        for (int k = 0; k < 6; k++) exp_d[5 + k] = 8'h44 + 8'(k);
        exp_g[0] = 4'b0001; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
        check_log("t4", base, 11);
        check_grants("t4", gb, 4);

        // reset mid-burst on req2
        clear_model();
        load(2, 8'h60, 3);
        base = wn;
        for (int k = 0; k < 10 && wn == base; k++) tick();
        check("t5_started", wn - base, 1);
        check("t5_pre_grant", grant_out, 4'b0100);
        #2;
        nrst_in = 1'b0;
        #1;
        check("t5_rst_grant", grant_out, 0);
        check("t5_rst_write", fifo_write_out, 0);
        check("t5_rst_ready", req_ready_out, 0);
        check("t5_rst_busy", busy_out, 0);
        check("t5_rst_wdata", fifo_wdata_out, 0);
        clear_model();
        req_valid_in = '0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        nrst_in = 1'b1;
        prev_grant = '0;
        load(0, 8'h70, 1);
        load(2, 8'h71, 1);
        base = wn; gb = gn;
        repeat (8) tick();
        exp_d[0] = 8'h70; exp_d[1] = 8'h71;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0100;
        check_log("t5", base, 2);
        check_grants("t5", gb, 2);

        // req1 drops valid mid-packet while req0 waits
        clear_model();
        load(1, 8'h80, 3);
        base = wn; gb = gn;
        for (int k = 0; k < 10 && wn == base; k++) tick();
        load(0, 8'h90, 1);
        stall_at = base + 1; stall_left = 5; stall_kind = 1; stall_grant = 4'b0010;
        stall_cycles = 0; stall_err = 0;
        repeat (16) tick();
        exp_d[0] = 8'h80; exp_d[1] = 8'h81; exp_d[2] = 8'h82; exp_d[3] = 8'h90;
        exp_g[0] = 4'b0010; exp_g[1] = 4'b0001;
        check_log("t6", base, 4);
        check_grants("t6", gb, 2);
        check("t6_stall_cycles", stall_cycles, 5);
        check("t6_stall_err", stall_err, 0);

        check("invariants", inv_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
